pong_pixel_gen: RTL and testbench

- Stage directly downstream of the VGA timing controller. Consumes its hcount/vcount/vga_blank_n and drives the 4-bit RGB inputs.
- Holds the Pong game state: two paddles, one ball, scores and a serve/play/point/over state machine.
- Game state updates once per frame at vertical-blank entry. Per-pixel RGB is rendered from that state with a 1-clk registered latency.

---
 rtl/pong_pixel_gen.sv | 206 ++++++++++++++++++++
 tb/tb_pong_pixel_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_pixel_gen.sv
// Pong game-state machine and per-pixel renderer sitting behind the VGA timing controller.
// State advances once per frame at vertical-blank entry; RGB is registered one clk after hcount/vcount.
module pong_pixel_gen #(
    parameter int H_OFFSET     = 158,
    parameter int SCREEN_W     = 620,
    parameter int SCREEN_H     = 480,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_X_OFF = 16,
    parameter int PADDLE_SPEED = 6,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30,
    parameter int WIN_SCORE    = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] hcount,
    input  logic [15:0] vcount,
    input  logic        blank_n,
    input  logic        p1_up,
    input  logic        p1_dn,
    input  logic        p2_up,
    input  logic        p2_dn,
    input  logic        start,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        frame_tick,
    output logic        game_over
);
    localparam logic [1:0] S_SERVE = 2'd0, S_PLAY = 2'd1, S_POINT = 2'd2, S_OVER = 2'd3;

    localparam logic signed [11:0] SPD   = 12'(BALL_SPEED);
    localparam logic signed [11:0] BS    = 12'(BALL_SIZE);
    localparam logic signed [11:0] LPR   = 12'(PADDLE_X_OFF + PADDLE_W);
    localparam logic signed [11:0] RPL   = 12'(SCREEN_W - PADDLE_X_OFF - PADDLE_W);
    localparam logic signed [11:0] X0    = 12'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic signed [11:0] Y0    = 12'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic signed [11:0] XMAX  = 12'(SCREEN_W - BALL_SIZE);
    localparam logic signed [11:0] YMAX  = 12'(SCREEN_H - BALL_SIZE);
    localparam logic signed [11:0] PH    = 12'(PADDLE_H);
    localparam logic signed [11:0] PS    = 12'(PADDLE_SPEED);
    localparam logic signed [11:0] PYMAX = 12'(SCREEN_H - PADDLE_H);
    localparam logic signed [11:0] PY0   = 12'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [3:0]         WIN   = 4'(WIN_SCORE);

    logic [1:0]         state, state_n;
    logic [7:0]         cnt, cnt_n;
    logic signed [11:0] bx, by, dx, dy, ply, pry;
    logic signed [11:0] bx_n, by_n, dx_n, dy_n, nx, ny;
    logic [3:0]         sl_n, sr_n;
    logic               vblank_q, in_vb, hit_l, hit_r;

    assign in_vb      = (vcount >= 16'(SCREEN_H));
    assign frame_tick = in_vb & ~vblank_q;
    assign game_over  = (state == S_OVER);

    function automatic logic signed [11:0] paddle_step(input logic signed [11:0] y,
                                                       input logic up, input logic dn);
        logic signed [11:0] t;
        t = y;
        if (up && !dn)      t = (y < PS) ? 12'sd0 : y - PS;
        else if (dn && !up) t = (y > PYMAX - PS) ? PYMAX : y + PS;
        return t;
    endfunction

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bx_n    = bx;
        by_n    = by;
        dx_n    = dx;
        dy_n    = dy;
        sl_n    = score_l;
        sr_n    = score_r;
        nx      = bx + dx;
        ny      = by + dy;
        // Paddle overlap uses the pre-tick ball and paddle positions.
        hit_l   = (dx < 12'sd0) && (bx >= LPR) && (nx < LPR) && (by + BS > ply) && (by < ply + PH);
        hit_r   = (dx > 12'sd0) && (bx + BS <= RPL) && (nx + BS > RPL) && (by + BS > pry) && (by < pry + PH);
        case (state)
            S_SERVE: begin
                if (cnt == 8'(SERVE_FRAMES - 1)) begin
                    state_n = S_PLAY;
                    cnt_n   = 8'd0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_PLAY: begin
                if (ny < 12'sd0) begin
                    by_n = 12'sd0;
                    dy_n = SPD;
                end else if (ny > YMAX) begin
                    by_n = YMAX;
                    dy_n = -SPD;
                end else begin
                    by_n = ny;
                end
                if (hit_l) begin
                    bx_n = LPR;
                    dx_n = SPD;
                end else if (hit_r) begin
                    bx_n = RPL - BS;
                    dx_n = -SPD;
                end else if (nx < 12'sd0) begin
                    sr_n    = (score_r == WIN) ? score_r : score_r + 4'd1;
                    dx_n    = -SPD;
                    state_n = S_POINT;
                    cnt_n   = 8'd0;
                end else if (nx > XMAX) begin
                    sl_n    = (score_l == WIN) ? score_l : score_l + 4'd1;
                    dx_n    = SPD;
                    state_n = S_POINT;
                    cnt_n   = 8'd0;
                end else begin
                    bx_n = nx;
                end
            end
            S_POINT: begin
                if (cnt == 8'(POINT_FRAMES - 1)) begin
                    cnt_n   = 8'd0;
                    bx_n    = X0;
                    by_n    = Y0;
                    state_n = (score_l == WIN || score_r == WIN) ? S_OVER : S_SERVE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                if (start) begin
                    sl_n    = 4'd0;
                    sr_n    = 4'd0;
                    bx_n    = X0;
                    by_n    = Y0;
                    cnt_n   = 8'd0;
                    state_n = S_SERVE;
                end
            end
        endcase
    end

    logic [15:0] px, bx16, by16, ply16, pry16;
    logic        ball_on, lpad_on, rpad_on, net_on;
    logic [11:0] rgb_n;

    always_comb begin
        px      = hcount - 16'(H_OFFSET);
        bx16    = 16'(bx);
        by16    = 16'(by);
        ply16   = 16'(ply);
        pry16   = 16'(pry);
        ball_on = (state != S_OVER) && (px >= bx16) && (px < bx16 + 16'(BALL_SIZE))
                  && (vcount >= by16) && (vcount < by16 + 16'(BALL_SIZE));
        lpad_on = (px >= 16'(PADDLE_X_OFF)) && (px < 16'(PADDLE_X_OFF + PADDLE_W))
                  && (vcount >= ply16) && (vcount < ply16 + 16'(PADDLE_H));
        rpad_on = (px >= 16'(SCREEN_W - PADDLE_X_OFF - PADDLE_W)) && (px < 16'(SCREEN_W - PADDLE_X_OFF))
                  && (vcount >= pry16) && (vcount < pry16 + 16'(PADDLE_H));
        net_on  = ((px == 16'(SCREEN_W / 2 - 1)) || (px == 16'(SCREEN_W / 2))) && !vcount[4];
        rgb_n   = 12'h000;
        if (blank_n && hcount >= 16'(H_OFFSET)) begin
            if (ball_on)      rgb_n = 12'hFFF;
            else if (lpad_on) rgb_n = 12'h0F0;
            else if (rpad_on) rgb_n = 12'h00F;
            else if (net_on)  rgb_n = 12'h888;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vblank_q  <= 1'b1;
            state     <= S_SERVE;
            cnt       <= 8'd0;
            bx        <= X0;
            by        <= Y0;
            dx        <= SPD;
            dy        <= -SPD;
            ply       <= PY0;
            pry       <= PY0;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            {r, g, b} <= 12'h000;
        end else begin
            vblank_q  <= in_vb;
            {r, g, b} <= rgb_n;
            if (frame_tick) begin
                state   <= state_n;
                cnt     <= cnt_n;
                bx      <= bx_n;
                by      <= by_n;
                dx      <= dx_n;
                dy      <= dy_n;
                score_l <= sl_n;
                score_r <= sr_n;
                if (state != S_OVER) begin
                    ply <= paddle_step(ply, p1_up, p1_dn);
                    pry <= paddle_step(pry, p2_up, p2_dn);
                end
            end
        end
    end
endmodule

// File: tb/tb_pong_pixel_gen.sv
// Bench for pong_pixel_gen: short synthetic frames, game rules modelled with plain integers,
// state observed through rendered pixels, scores and status outputs.
module tb_pong_pixel_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] hcount, vcount;
    logic        blank_n, p1_up, p1_dn, p2_up, p2_dn, start;
    logic [3:0]  r, g, b, score_l, score_r;
    logic        frame_tick, game_over;

    int checks = 0;
    int errors = 0;

    // Reference game state: st 0 serve, 1 play, 2 point, 3 over
    int mbx, mby, mdx, mdy, mpl, mpr, msl, msr, mst, mcnt;

    pong_pixel_gen dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .blank_n(blank_n),
        .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn), .start(start),
        .r(r), .g(g), .b(b), .score_l(score_l), .score_r(score_r),
        .frame_tick(frame_tick), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mbx = 306; mby = 236; mdx = 4; mdy = -4;
        mpl = 208; mpr = 208; msl = 0; msr = 0; mst = 0; mcnt = 0;
    endtask

    function automatic int pad_move(input int p, input bit up, input bit dn);
        if (up && !dn) return (p - 6 < 0) ? 0 : p - 6;
        if (dn && !up) return (p + 6 > 416) ? 416 : p + 6;
        return p;
    endfunction

    function automatic bit overlaps(input int ball_y, input int pad_y);
        return (ball_y + 8 > pad_y) && (ball_y < pad_y + 64);
    endfunction

    task automatic model_tick(input bit u1, input bit d1, input bit u2, input bit d2, input bit st);
        int nx, ny, oy;
        bit was_over;
        was_over = (mst == 3);
        case (mst)
            0: begin
                mcnt++;
                if (mcnt == 60) begin mst = 1; mcnt = 0; end
            end
            1: begin
                nx = mbx + mdx; ny = mby + mdy; oy = mby;
                if (ny < 0)        begin mby = 0;   mdy = 4;  end
                else if (ny > 472) begin mby = 472; mdy = -4; end
                else mby = ny;
                if (mdx < 0 && mbx >= 24 && nx < 24 && overlaps(oy, mpl)) begin mbx = 24; mdx = 4; end
                else if (mdx > 0 && mbx + 8 <= 596 && nx + 8 > 596 && overlaps(oy, mpr)) begin mbx = 588; mdx = -4; end
                else if (nx < 0)   begin if (msr < 9) msr++; mdx = -4; mst = 2; mcnt = 0; end
                else if (nx > 612) begin if (msl < 9) msl++; mdx = 4;  mst = 2; mcnt = 0; end
                else mbx = nx;
            end
            2: begin
                mcnt++;
                if (mcnt == 30) begin
                    mcnt = 0; mbx = 306; mby = 236;
                    mst = (msl == 9 || msr == 9) ? 3 : 0;
                end
            end
            default: if (st) begin msl = 0; msr = 0; mbx = 306; mby = 236; mst = 0; mcnt = 0; end
        endcase
        if (!was_over) begin
            mpl = pad_move(mpl, u1, d1);
            mpr = pad_move(mpr, u2, d2);
        end
    endtask

    function automatic logic [11:0] model_rgb(input int x, input int y);
        if (mst != 3 && x >= mbx && x < mbx + 8 && y >= mby && y < mby + 8) return 12'hFFF;
        if (x >= 16 && x < 24 && y >= mpl && y < mpl + 64) return 12'h0F0;
        if (x >= 596 && x < 604 && y >= mpr && y < mpr + 64) return 12'h00F;
        if ((x == 309 || x == 310) && ((y / 16) % 2 == 0)) return 12'h888;
        return 12'h000;
    endfunction

    // Entered and left at a negedge; rgb for the presented pixel is registered in between.
    task automatic probe(input int x, input int y);
        logic [11:0] exp;
        if (x < 0 || x >= 620 || y < 0 || y >= 480) return;
        hcount = 16'(158 + x); vcount = 16'(y); blank_n = 1'b1;
        @(negedge clk);
        exp = model_rgb(x, y);
        checks++;
        if ({r, g, b} !== exp) begin
            errors++;
            $display("FAIL pixel(%0d,%0d) got %h want %h", x, y, {r, g, b}, exp);
        end
    endtask

    task automatic check_frame();
        checks++;
        if (score_l !== 4'(msl) || score_r !== 4'(msr) || game_over !== (mst == 3)) begin
            errors++;
            $display("FAIL status got l=%0d r=%0d over=%b want l=%0d r=%0d over=%b",
                     score_l, score_r, game_over, msl, msr, mst == 3);
        end
        probe(mbx, mby);
        probe(mbx + 7, mby + 7);
        probe(mbx - 1, mby);
        probe(mbx + 3, mby + 8);
        probe(16 + int'($urandom_range(0, 7)), mpl);
        probe(20, mpl + 64);
        probe(596 + int'($urandom_range(0, 7)), mpr + 63);
        probe(600, mpr - 1);
        probe(int'($urandom_range(0, 619)), int'($urandom_range(0, 479)));
    endtask

    task automatic frame(input bit u1, input bit d1, input bit u2, input bit d2, input bit st);
        p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2; start = st;
        blank_n = 1'b0; hcount = 16'd0; vcount = 16'd0;
        @(negedge clk);
        vcount = 16'(480 + $urandom_range(0, 40));
        #1;
        checks++;
        if (frame_tick !== 1'b1) begin errors++; $display("FAIL tick_rise got %b want 1", frame_tick); end
        @(negedge clk);
        model_tick(u1, d1, u2, d2, st);
        checks++;
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL tick_width got %b want 0", frame_tick); end
        start = 1'b0;
        check_frame();
    endtask

    task automatic test_reset();
        rst = 1'b1; blank_n = 1'b0; hcount = 16'd0; vcount = 16'd500;
        p1_up = 0; p1_dn = 0; p2_up = 0; p2_dn = 0; start = 0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({r, g, b} !== 12'h000 || score_l !== 4'd0 || score_r !== 4'd0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got rgb=%h l=%0d r=%0d over=%b want 000 0 0 0",
                     {r, g, b}, score_l, score_r, game_over);
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_no_tick got %b want 0", frame_tick); end
        probe(306, 236);
        probe(313, 243);
        probe(314, 236);
        probe(305, 243);
        check_frame();
    endtask

    task automatic test_blank();
        for (int i = 0; i < 8; i++) begin
            hcount = 16'(158 + $urandom_range(300, 313)); vcount = 16'($urandom_range(230, 245));
            blank_n = 1'b0;
            @(negedge clk);
            checks++;
            if ({r, g, b} !== 12'h000) begin errors++; $display("FAIL blank_n got %h want 000", {r, g, b}); end
            hcount = 16'($urandom_range(0, 157)); blank_n = 1'b1;
            @(negedge clk);
            checks++;
            if ({r, g, b} !== 12'h000) begin errors++; $display("FAIL h_offset got %h want 000", {r, g, b}); end
        end
    endtask

    task automatic test_serve();
        for (int f = 0; f < 130; f++) frame(0, 0, 0, 0, 0);
    endtask

    task automatic test_paddle();
        for (int f = 0; f < 40; f++) frame(1, 0, 0, 1, 0);
        for (int f = 0; f < 5; f++)  frame(1, 1, 1, 1, 0);
        for (int f = 0; f < 20; f++) frame(0, 1, 1, 0, 0);
    endtask

    task automatic test_game_over();
        int tgt;
        bit u1;
        rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset();
        // Left paddle dodges the ball, right paddle tracks it: the right side collects the points.
        for (int f = 0; f < 4000 && mst != 3; f++) begin
            tgt = mby - 28;
            u1 = (mby >= 208);
            frame(u1, !u1, mpr > tgt + 2, mpr < tgt - 2, 0);
        end
        checks++;
        if (game_over !== 1'b1) begin errors++; $display("FAIL game_over_reached got %b want 1", game_over); end
        for (int f = 0; f < 4; f++)
            frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
        probe(306, 236);
        frame(0, 0, 0, 0, 1);
        checks++;
        if (score_l !== 4'd0 || score_r !== 4'd0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL restart got l=%0d r=%0d over=%b want 0 0 0", score_l, score_r, game_over);
        end
    endtask

    task automatic test_rally();
        int tgt;
        for (int f = 0; f < 250; f++) begin
            tgt = mby - 28;
            frame(mpl > tgt + 2, mpl < tgt - 2, mpr > tgt + 2, mpr < tgt - 2, 0);
        end
    endtask

    task automatic test_mid_reset();
        hcount = 16'(158 + 18); vcount = 16'(mpl); blank_n = 1'b1; rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({r, g, b} !== 12'h000 || score_l !== 4'd0 || score_r !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset got rgb=%h l=%0d r=%0d want 000 0 0", {r, g, b}, score_l, score_r);
        end
        rst = 1'b0;
        model_reset();
        check_frame();
        frame(0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 200; f++)
            frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
    endtask

    initial begin
        test_reset();
        test_blank();
        test_serve();
        test_paddle();
        test_game_over();
        test_rally();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
